// File: rtl/decode_issue.sv
// Decode/issue stage: decodes a two-slot bundle, tracks in-flight load
// destinations, issues slots to execute and interlocks fetch on hazards.
module decode_issue #(
    parameter logic [5:0]  NOP_OP     = 6'b000000,
    parameter logic [5:0]  LOAD_MASK  = 6'b111000,
    parameter logic [5:0]  LOAD_MATCH = 6'b010000,
    parameter logic [5:0]  NOWB_MASK  = 6'b111000,
    parameter logic [5:0]  NOWB_MATCH = 6'b011000,
    parameter int unsigned LOAD_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [63:0] inst_in,
    input  logic        branch_flag,
    output logic        interlock,
    output logic [31:0] pc_out,
    output logic [31:0] inst0_out,
    output logic [31:0] inst1_out,
    output logic        valid0_out,
    output logic        valid1_out
);

    localparam logic [31:0] NOP_INST = {NOP_OP, 26'b0};
    localparam logic [1:0]  LAT      = 2'(LOAD_LAT);

    typedef enum logic {
        ST_FULL   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_busy_cnt [32];
    logic [31:0] w_busy;
    logic [31:0] w_set;
    logic [31:0] w_slot0;
    logic [31:0] w_slot1;
    logic        w_empty0;
    logic        w_empty1;
    logic        w_haz0;
    logic        w_haz1;
    logic        w_dep;
    logic        w_issue0;
    logic        w_issue1;

    function automatic logic f_empty(input logic [31:0] inst);
        return inst[31:26] == NOP_OP;
    endfunction

    function automatic logic f_is_load(input logic [31:0] inst);
        return !f_empty(inst) && ((inst[31:26] & LOAD_MASK) == LOAD_MATCH);
    endfunction

    function automatic logic f_writes_rd(input logic [31:0] inst);
        return !f_empty(inst) && ((inst[31:26] & NOWB_MASK) != NOWB_MATCH)
            && (inst[25:21] != 5'd0);
    endfunction

    function automatic logic f_hazard(input logic [31:0] inst, input logic [31:0] busy);
        logic rs1_busy;
        logic rs2_busy;
        rs1_busy = (inst[20:16] != 5'd0) && busy[inst[20:16]];
        rs2_busy = (inst[15:11] != 5'd0) && busy[inst[15:11]];
        return !f_empty(inst) && (rs1_busy || rs2_busy);
    endfunction

    assign w_slot0  = inst_in[63:32];
    assign w_slot1  = inst_in[31:0];
    assign w_empty0 = f_empty(w_slot0);
    assign w_empty1 = f_empty(w_slot1);

    // Busy flags from the scoreboard and per-slot hazard / dependency decode
    always_comb begin
        w_busy = 32'd0;
        for (int i = 0; i < 32; i++) begin
            w_busy[i] = (r_busy_cnt[i] != 2'd0);
        end
        w_haz0 = f_hazard(w_slot0, w_busy);
        w_haz1 = f_hazard(w_slot1, w_busy);
        // Slot1 must wait for slot0 on RAW or WAW against slot0's destination
        w_dep  = f_writes_rd(w_slot0) && !w_empty1
              && ((w_slot1[20:16] == w_slot0[25:21])
               || (w_slot1[15:11] == w_slot0[25:21])
               || (f_writes_rd(w_slot1) && (w_slot1[25:21] == w_slot0[25:21])));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FULL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        if (rst || branch_flag) begin
            w_state_next = ST_FULL;
        end else begin
            case (r_state)
                ST_FULL: begin
                    if (w_haz0) begin
                        w_state_next = ST_FULL;
                    end else if (w_empty0 && w_empty1) begin
                        w_state_next = ST_FULL;
                    end else if (w_dep || w_haz1) begin
                        w_state_next = ST_SECOND;
                    end else begin
                        w_state_next = ST_FULL;
                    end
                end
                ST_SECOND: begin
                    if (w_haz1) begin
                        w_state_next = ST_SECOND;
                    end else begin
                        w_state_next = ST_FULL;
                    end
                end
                default: w_state_next = ST_FULL;
            endcase
        end
    end

    // FSM outputs: issue decisions and the fetch interlock
    always_comb begin
        w_issue0  = 1'b0;
        w_issue1  = 1'b0;
        interlock = 1'b0;
        if (rst || branch_flag) begin
            interlock = 1'b0;
        end else begin
            case (r_state)
                ST_FULL: begin
                    if (w_haz0) begin
                        interlock = 1'b1;
                    end else if (w_empty0 && w_empty1) begin
                        interlock = 1'b0;
                    end else if (w_dep || w_haz1) begin
                        w_issue0  = 1'b1;
                        interlock = 1'b1;
                    end else begin
                        w_issue0  = 1'b1;
                        w_issue1  = 1'b1;
                    end
                end
                ST_SECOND: begin
                    if (w_haz1) begin
                        interlock = 1'b1;
                    end else begin
                        w_issue1 = 1'b1;
                    end
                end
                default: interlock = 1'b0;
            endcase
        end
    end

    // Scoreboard set requests from loads issued this cycle (r0 is never tracked)
    always_comb begin
        w_set = 32'd0;
        if (w_issue0 && f_is_load(w_slot0) && (w_slot0[25:21] != 5'd0)) begin
            w_set[w_slot0[25:21]] = 1'b1;
        end else begin
            w_set = w_set;
        end
        if (w_issue1 && f_is_load(w_slot1) && (w_slot1[25:21] != 5'd0)) begin
            w_set[w_slot1[25:21]] = 1'b1;
        end else begin
            w_set = w_set;
        end
    end

    // Scoreboard counters: a new load wins over the per-cycle decrement
    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (rst) begin
                r_busy_cnt[i] <= 2'd0;
            end else if (w_set[i]) begin
                r_busy_cnt[i] <= LAT;
            end else if (r_busy_cnt[i] != 2'd0) begin
                r_busy_cnt[i] <= r_busy_cnt[i] - 2'd1;
            end else begin
                r_busy_cnt[i] <= 2'd0;
            end
        end
    end

    // Issue registers toward execute; a bubble keeps the last PC
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out     <= 32'd0;
            inst0_out  <= NOP_INST;
            inst1_out  <= NOP_INST;
            valid0_out <= 1'b0;
            valid1_out <= 1'b0;
        end else if (branch_flag) begin
            pc_out     <= 32'd0;
            inst0_out  <= NOP_INST;
            inst1_out  <= NOP_INST;
            valid0_out <= 1'b0;
            valid1_out <= 1'b0;
        end else if (w_issue0 || w_issue1) begin
            pc_out     <= pc_in;
            inst0_out  <= w_issue0 ? w_slot0 : NOP_INST;
            inst1_out  <= w_issue1 ? w_slot1 : NOP_INST;
            valid0_out <= w_issue0 && !w_empty0;
            valid1_out <= w_issue1 && !w_empty1;
        end else begin
            pc_out     <= pc_out;
            inst0_out  <= NOP_INST;
            inst1_out  <= NOP_INST;
            valid0_out <= 1'b0;
            valid1_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: issue, load-use stall, split, branch flush,
// r0 handling, empty slots and reset during a split.
module tb_decode_issue;

    localparam logic [5:0]  ADD = 6'b000001;
    localparam logic [5:0]  SUB = 6'b000010;
    localparam logic [5:0]  LD  = 6'b010001;
    localparam logic [5:0]  ST  = 6'b011001;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [63:0] inst_in;
    logic        branch_flag;
    logic        interlock;
    logic [31:0] pc_out;
    logic [31:0] inst0_out;
    logic [31:0] inst1_out;
    logic        valid0_out;
    logic        valid1_out;

    int n_pass  = 0;
    int n_total = 0;

    wire [97:0] w_obs = {pc_out, inst0_out, inst1_out, valid0_out, valid1_out};

    decode_issue dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .inst_in    (inst_in),
        .branch_flag(branch_flag),
        .interlock  (interlock),
        .pc_out     (pc_out),
        .inst0_out  (inst0_out),
        .inst1_out  (inst1_out),
        .valid0_out (valid0_out),
        .valid1_out (valid1_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 11'd0};
    endfunction

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put(input logic [31:0] pc, input logic [31:0] s0, input logic [31:0] s1);
        pc_in   = pc;
        inst_in = {s0, s1};
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        branch_flag = 1'b0;
        put(32'h1234, mk(ADD, 5'd3, 5'd1, 5'd2), mk(ADD, 5'd4, 5'd5, 5'd6));
        step;
        n_total++;
        if (interlock !== 1'b0) $display("FAIL reset_interlock: got %b exp 0", interlock);
        else n_pass++;
        n_total++;
        if (w_obs !== {32'h0, NOP, NOP, 2'b00})
            $display("FAIL reset_outputs: got %h exp %h", w_obs, {32'h0, NOP, NOP, 2'b00});
        else n_pass++;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic;
        logic [31:0] a, b;
        a = mk(ADD, 5'd3, 5'd1, 5'd2);
        b = mk(ADD, 5'd4, 5'd5, 5'd6);
        put(32'h10, a, b);
        n_total++;
        if (interlock !== 1'b0) $display("FAIL basic_interlock: got %b exp 0", interlock);
        else n_pass++;
        step;
        n_total++;
        if (w_obs !== {32'h10, a, b, 2'b11})
            $display("FAIL basic_issue: got %h exp %h", w_obs, {32'h10, a, b, 2'b11});
        else n_pass++;
        n_total++;
        if (interlock !== 1'b0) $display("FAIL basic_interlock_after: got %b exp 0", interlock);
        else n_pass++;
    endtask

    task automatic test_load_use;
        logic [31:0] ld, a;
        ld = mk(LD, 5'd7, 5'd1, 5'd0);
        a  = mk(ADD, 5'd10, 5'd7, 5'd2);
        put(32'h20, ld, NOP);
        step;
        n_total++;
        if (w_obs !== {32'h20, ld, NOP, 2'b10})
            $display("FAIL load_issue: got %h exp %h", w_obs, {32'h20, ld, NOP, 2'b10});
        else n_pass++;
        put(32'h24, a, NOP);
        // r7 counter is 2 then 1: two stall cycles with bubbles
        for (int c = 0; c < 2; c++) begin
            n_total++;
            if (interlock !== 1'b1) $display("FAIL load_use_stall%0d: got %b exp 1", c, interlock);
            else n_pass++;
            step;
            n_total++;
            if (w_obs !== {32'h20, NOP, NOP, 2'b00})
                $display("FAIL load_use_bubble%0d: got %h exp %h", c, w_obs, {32'h20, NOP, NOP, 2'b00});
            else n_pass++;
        end
        n_total++;
        if (interlock !== 1'b0) $display("FAIL load_use_release: got %b exp 0", interlock);
        else n_pass++;
        step;
        n_total++;
        if (w_obs !== {32'h24, a, NOP, 2'b10})
            $display("FAIL load_use_issue: got %h exp %h", w_obs, {32'h24, a, NOP, 2'b10});
        else n_pass++;
    endtask

    task automatic test_split(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
        put(pc, a, b);
        n_total++;
        if (interlock !== 1'b1) $display("FAIL split_interlock1: got %b exp 1", interlock);
        else n_pass++;
        step;
        n_total++;
        if (w_obs !== {pc, a, NOP, 2'b10})
            $display("FAIL split_first: got %h exp %h", w_obs, {pc, a, NOP, 2'b10});
        else n_pass++;
        n_total++;
        if (interlock !== 1'b0) $display("FAIL split_interlock2: got %b exp 0", interlock);
        else n_pass++;
        step;
        n_total++;
        if (w_obs !== {pc, NOP, b, 2'b01})
            $display("FAIL split_second: got %h exp %h", w_obs, {pc, NOP, b, 2'b01});
        else n_pass++;
    endtask

    task automatic test_store_nowb;
        logic [31:0] s, a;
        s = mk(ST, 5'd22, 5'd1, 5'd2);
        a = mk(ADD, 5'd23, 5'd22, 5'd1);
        put(32'h90, s, a);
        n_total++;
        if (interlock !== 1'b0) $display("FAIL store_interlock: got %b exp 0", interlock);
        else n_pass++;
        step;
        n_total++;
        if (w_obs !== {32'h90, s, a, 2'b11})
            $display("FAIL store_issue: got %h exp %h", w_obs, {32'h90, s, a, 2'b11});
        else n_pass++;
    endtask

    task automatic test_branch_in_split;
        logic [31:0] ld, b, a;
        ld = mk(LD, 5'd13, 5'd1, 5'd0);
        b  = mk(ADD, 5'd14, 5'd13, 5'd1);
        a  = mk(ADD, 5'd15, 5'd13, 5'd2);
        put(32'h44, ld, b);
        step;
        n_total++;
        if (w_obs !== {32'h44, ld, NOP, 2'b10})
            $display("FAIL br_split_first: got %h exp %h", w_obs, {32'h44, ld, NOP, 2'b10});
        else n_pass++;
        n_total++;
        if (interlock !== 1'b1) $display("FAIL br_second_hazard: got %b exp 1", interlock);
        else n_pass++;
        branch_flag = 1'b1;
        #1;
        n_total++;
        if (interlock !== 1'b0) $display("FAIL br_interlock: got %b exp 0", interlock);
        else n_pass++;
        step;
        n_total++;
        if (w_obs !== {32'h0, NOP, NOP, 2'b00})
            $display("FAIL br_flush: got %h exp %h", w_obs, {32'h0, NOP, NOP, 2'b00});
        else n_pass++;
        branch_flag = 1'b0;
        put(32'h50, a, NOP);
        // r13 load still in flight with one cycle left
        n_total++;
        if (interlock !== 1'b1) $display("FAIL br_load_inflight: got %b exp 1", interlock);
        else n_pass++;
        step;
        n_total++;
        if (w_obs !== {32'h0, NOP, NOP, 2'b00})
            $display("FAIL br_bubble_pc: got %h exp %h", w_obs, {32'h0, NOP, NOP, 2'b00});
        else n_pass++;
        n_total++;
        if (interlock !== 1'b0) $display("FAIL br_load_done: got %b exp 0", interlock);
        else n_pass++;
        step;
        n_total++;
        if (w_obs !== {32'h50, a, NOP, 2'b10})
            $display("FAIL br_full_issue: got %h exp %h", w_obs, {32'h50, a, NOP, 2'b10});
        else n_pass++;
    endtask

    task automatic test_r0;
        logic [31:0] ld, a, b;
        ld = mk(LD, 5'd0, 5'd1, 5'd2);
        a  = mk(ADD, 5'd16, 5'd0, 5'd0);
        b  = mk(ADD, 5'd17, 5'd0, 5'd1);
        put(32'h60, ld, NOP);
        step;
        put(32'h64, a, b);
        n_total++;
        if (interlock !== 1'b0) $display("FAIL r0_no_stall: got %b exp 0", interlock);
        else n_pass++;
        step;
        n_total++;
        if (w_obs !== {32'h64, a, b, 2'b11})
            $display("FAIL r0_issue: got %h exp %h", w_obs, {32'h64, a, b, 2'b11});
        else n_pass++;
    endtask

    task automatic test_reset_mid_split;
        logic [31:0] ld, b, a;
        ld = mk(LD, 5'd18, 5'd1, 5'd0);
        b  = mk(ADD, 5'd19, 5'd18, 5'd2);
        a  = mk(ADD, 5'd20, 5'd18, 5'd1);
        put(32'h70, ld, b);
        n_total++;
        if (interlock !== 1'b1) $display("FAIL rs_split_interlock: got %b exp 1", interlock);
        else n_pass++;
        step;
        rst = 1'b1;
        #1;
        n_total++;
        if (interlock !== 1'b0) $display("FAIL rs_interlock: got %b exp 0", interlock);
        else n_pass++;
        step;
        n_total++;
        if (w_obs !== {32'h0, NOP, NOP, 2'b00})
            $display("FAIL rs_outputs: got %h exp %h", w_obs, {32'h0, NOP, NOP, 2'b00});
        else n_pass++;
        rst = 1'b0;
        put(32'h74, a, NOP);
        n_total++;
        if (interlock !== 1'b0) $display("FAIL rs_counters_clear: got %b exp 0", interlock);
        else n_pass++;
        step;
        n_total++;
        if (w_obs !== {32'h74, a, NOP, 2'b10})
            $display("FAIL rs_full_issue: got %h exp %h", w_obs, {32'h74, a, NOP, 2'b10});
        else n_pass++;
    endtask

    task automatic test_empty_slots;
        logic [31:0] b;
        b = mk(ADD, 5'd21, 5'd1, 5'd2);
        put(32'h80, NOP, NOP);
        n_total++;
        if (interlock !== 1'b0) $display("FAIL empty_interlock: got %b exp 0", interlock);
        else n_pass++;
        step;
        n_total++;
        if (w_obs !== {32'h74, NOP, NOP, 2'b00})
            $display("FAIL empty_bubble: got %h exp %h", w_obs, {32'h74, NOP, NOP, 2'b00});
        else n_pass++;
        put(32'h84, NOP, b);
        step;
        n_total++;
        if (w_obs !== {32'h84, NOP, b, 2'b01})
            $display("FAIL empty_slot0: got %h exp %h", w_obs, {32'h84, NOP, b, 2'b01});
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        branch_flag = 1'b0;
        pc_in = 32'd0;
        inst_in = 64'd0;
        test_reset;
        test_basic;
        test_load_use;
        test_split(32'h30, mk(ADD, 5'd8, 5'd1, 5'd2), mk(SUB, 5'd9, 5'd8, 5'd1));
        test_split(32'h38, mk(ADD, 5'd11, 5'd1, 5'd2), mk(ADD, 5'd11, 5'd3, 5'd4));
        test_store_nowb;
        test_branch_in_split;
        test_r0;
        test_reset_mid_split;
        test_empty_slots;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
